// File: rtl/division_sign_restore_pkg.sv
// Shared definitions for the signed-result restore stage of the divider:
// default width, FSM encoding and the per-operand negate flags.
package division_sign_restore_pkg;

    localparam int unsigned DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } div_state_e;

    typedef struct packed {
        logic neg_quo;
        logic neg_rem;
    } div_neg_t;

    // Quotient is negative when the operand signs differ; remainder follows the dividend.
    function automatic div_neg_t neg_flags(input logic sign_a, input logic sign_b);
        div_neg_t f;
        f.neg_quo = sign_a ^ sign_b;
        f.neg_rem = sign_a;
        return f;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder used by the bit-serial sign restore datapath.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/division_sign_restore.sv
// Converts unsigned quotient/remainder magnitudes to two's complement, one bit
// per cycle LSB first, with a fixed latency of WIDTH cycles in CONVERT.
module division_sign_restore
    import division_sign_restore_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restore_sel,
    input  logic [WIDTH-1:0] q_mag,
    input  logic [WIDTH-1:0] r_mag,
    input  logic             sign_a,
    input  logic             sign_b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             restore_finish,
    output logic             overflow
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    div_state_e       state_q;
    div_neg_t         neg_flags_q;
    logic [WIDTH-1:0] q_sr_q;
    logic [WIDTH-1:0] r_sr_q;
    logic [WIDTH-1:0] q_sr_d;
    logic [WIDTH-1:0] r_sr_d;
    logic [CNT_W-1:0] cnt_q;
    logic             q_carry_q;
    logic             r_carry_q;
    logic             ovf_q;

    logic             first_bit_c;
    logic             q_cin_c;
    logic             r_cin_c;
    logic             q_sum_c;
    logic             r_sum_c;
    logic             q_cout_c;
    logic             r_cout_c;

    // A negated magnitude may reach 2^(W-1); a positive one must stay below it.
    function automatic logic mag_ovf(input logic [WIDTH-1:0] mag, input logic neg);
        logic low_nonzero;
        low_nonzero = |mag[WIDTH-2:0];
        return neg ? (mag[WIDTH-1] & low_nonzero) : mag[WIDTH-1];
    endfunction

    // Bit 0 takes the +1 of ~x+1 as carry-in; later bits take the registered carry.
    assign first_bit_c = (cnt_q == '0);
    assign q_cin_c     = first_bit_c ? neg_flags_q.neg_quo : q_carry_q;
    assign r_cin_c     = first_bit_c ? neg_flags_q.neg_rem : r_carry_q;

    full_adder u_fa_quo (
        .a_i    (q_sr_q[0] ^ neg_flags_q.neg_quo),
        .b_i    (1'b0),
        .cin_i  (q_cin_c),
        .sum_o  (q_sum_c),
        .cout_o (q_cout_c)
    );

    full_adder u_fa_rem (
        .a_i    (r_sr_q[0] ^ neg_flags_q.neg_rem),
        .b_i    (1'b0),
        .cin_i  (r_cin_c),
        .sum_o  (r_sum_c),
        .cout_o (r_cout_c)
    );

    assign q_sr_d = {q_sum_c, q_sr_q[WIDTH-1:1]};
    assign r_sr_d = {r_sum_c, r_sr_q[WIDTH-1:1]};

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            neg_flags_q    <= '0;
            q_sr_q         <= '0;
            r_sr_q         <= '0;
            cnt_q          <= '0;
            q_carry_q      <= 1'b0;
            r_carry_q      <= 1'b0;
            ovf_q          <= 1'b0;
            quotient       <= '0;
            remainder      <= '0;
            busy           <= 1'b0;
            restore_finish <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            restore_finish <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (restore_sel) begin
                        q_sr_q      <= q_mag;
                        r_sr_q      <= r_mag;
                        neg_flags_q <= neg_flags(sign_a, sign_b);
                        cnt_q       <= '0;
                        q_carry_q   <= 1'b0;
                        r_carry_q   <= 1'b0;
                        ovf_q       <= mag_ovf(q_mag, sign_a ^ sign_b) | mag_ovf(r_mag, sign_a);
                        busy        <= 1'b1;
                        state_q     <= CONVERT;
                    end
                end
                CONVERT: begin
                    q_sr_q    <= q_sr_d;
                    r_sr_q    <= r_sr_d;
                    q_carry_q <= q_cout_c;
                    r_carry_q <= r_cout_c;
                    cnt_q     <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        quotient       <= q_sr_d;
                        remainder      <= r_sr_d;
                        overflow       <= ovf_q;
                        restore_finish <= 1'b1;
                        busy           <= 1'b0;
                        state_q        <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_division_sign_restore.sv
// Self-checking bench for division_sign_restore: vector table, scoreboard of
// expected completions, plus reset-mid-conversion and held-request sequences.
module tb_division_sign_restore;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         restore_sel;
    logic [W-1:0] q_mag;
    logic [W-1:0] r_mag;
    logic         sign_a;
    logic         sign_b;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         restore_finish;
    logic         overflow;

    division_sign_restore #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .restore_sel    (restore_sel),
        .q_mag          (q_mag),
        .r_mag          (r_mag),
        .sign_a         (sign_a),
        .sign_b         (sign_b),
        .quotient       (quotient),
        .remainder      (remainder),
        .busy           (busy),
        .restore_finish (restore_finish),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] qm;
        logic [W-1:0] rm;
        logic         sa;
        logic         sb;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         eo;
    } vec_t;

    typedef struct {
        int           id;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         eo;
        int           due;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    vec_t         vecs[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    bit           mon_en  = 1'b0;
    logic [W-1:0] hold_q  = '0;
    logic [W-1:0] hold_r  = '0;
    logic         hold_o  = 1'b0;

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (id %0d, cycle %0d): got %0h, required %0h", name, id, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Arithmetic reference: two's-complement negate and signed range check.
    function automatic vec_t make_vec(input logic [W-1:0] qm, input logic [W-1:0] rm,
                                      input logic sa, input logic sb);
        vec_t v;
        logic nq;
        nq   = sa ^ sb;
        v.qm = qm;
        v.rm = rm;
        v.sa = sa;
        v.sb = sb;
        v.eq = nq ? W'(0 - int'(qm)) : qm;
        v.er = sa ? W'(0 - int'(rm)) : rm;
        v.eo = (nq ? (int'(qm) > 128) : (int'(qm) > 127)) ||
               (sa ? (int'(rm) > 128) : (int'(rm) > 127));
        return v;
    endfunction

    task automatic push_exp(input int id, input vec_t v, input int due);
        exp_t e;
        e.id  = id;
        e.eq  = v.eq;
        e.er  = v.er;
        e.eo  = v.eo;
        e.due = due;
        sb_q.push_back(e);
    endtask

    task automatic drive_inputs(input vec_t v);
        q_mag  = v.qm;
        r_mag  = v.rm;
        sign_a = v.sa;
        sign_b = v.sb;
    endtask

    task automatic scramble_inputs();
        q_mag  = W'($urandom);
        r_mag  = W'($urandom);
        sign_a = 1'($urandom);
        sign_b = 1'($urandom);
    endtask

    // One complete conversion from IDLE; returns with the DUT back in IDLE.
    task automatic run_vec(input int id, input vec_t v);
        int n;
        drive_inputs(v);
        restore_sel = 1'b1;
        n = cyc + 1;
        push_exp(id, v, n + int'(W));
        tick();
        restore_sel = 1'b0;
        scramble_inputs();
        check("busy_start", id, busy, 1);
        repeat (W - 1) tick();
        check("busy_last_bit", id, busy, 1);
        tick();
        check("busy_done", id, busy, 0);
        tick();
    endtask

    // Compare every completion against the scoreboard; otherwise outputs must hold.
    always @(negedge clk) begin
        if (mon_en) begin
            if (restore_finish) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_finish (cycle %0d): restore_finish=1, required 0 with nothing pending", cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("latency", mon_e.id, cyc, mon_e.due);
                    check("quotient", mon_e.id, quotient, mon_e.eq);
                    check("remainder", mon_e.id, remainder, mon_e.er);
                    check("overflow", mon_e.id, overflow, mon_e.eo);
                    hold_q = mon_e.eq;
                    hold_r = mon_e.er;
                    hold_o = mon_e.eo;
                end
            end else begin
                check("hold_outputs", -1, {quotient, remainder, overflow}, {hold_q, hold_r, hold_o});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int id;
        int n;
        int cap;
        vec_t v;
        vec_t hv[4];

        // Hand-computed vectors: corners around 0, 2^(W-1) and 2^(W-1)+1.
        vecs.push_back('{8'h05, 8'h03, 1'b1, 1'b0, 8'hFB, 8'hFD, 1'b0});
        vecs.push_back('{8'h07, 8'h02, 1'b1, 1'b1, 8'h07, 8'hFE, 1'b0});
        vecs.push_back('{8'h80, 8'h00, 1'b0, 1'b1, 8'h80, 8'h00, 1'b0});
        vecs.push_back('{8'h80, 8'h00, 1'b0, 1'b0, 8'h80, 8'h00, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0});
        vecs.push_back('{8'h81, 8'h00, 1'b1, 1'b1, 8'h81, 8'h00, 1'b1});
        vecs.push_back('{8'h81, 8'h01, 1'b1, 1'b0, 8'h7F, 8'hFF, 1'b1});
        vecs.push_back('{8'h01, 8'h80, 1'b0, 1'b0, 8'h01, 8'h80, 1'b1});
        vecs.push_back('{8'h7F, 8'h80, 1'b1, 1'b1, 8'h7F, 8'h80, 1'b0});
        vecs.push_back('{8'hFF, 8'h7F, 1'b0, 1'b1, 8'h01, 8'h7F, 1'b1});
        vecs.push_back('{8'h12, 8'h34, 1'b0, 1'b0, 8'h12, 8'h34, 1'b0});
        vecs.push_back('{8'h7F, 8'h7F, 1'b1, 1'b0, 8'h81, 8'h81, 1'b0});
        for (int i = 0; i < 10; i++) begin
            vecs.push_back(make_vec(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom)));
        end

        rst         = 1'b1;
        restore_sel = 1'b0;
        q_mag       = '0;
        r_mag       = '0;
        sign_a      = 1'b0;
        sign_b      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_quotient", 0, quotient, 0);
        check("reset_remainder", 0, remainder, 0);
        check("reset_busy", 0, busy, 0);
        check("reset_finish", 0, restore_finish, 0);
        check("reset_overflow", 0, overflow, 0);
        mon_en = 1'b1;
        tick();

        id = 1;
        foreach (vecs[i]) begin
            run_vec(id, vecs[i]);
            id++;
        end

        // Reset at N+4 together with a request: reset wins, partial result is dropped.
        run_vec(id, vecs[0]);
        id++;
        drive_inputs(vecs[1]);
        restore_sel = 1'b1;
        n = cyc + 1;
        tick();
        restore_sel = 1'b0;
        while (cyc < n + 3) tick();
        rst         = 1'b1;
        restore_sel = 1'b1;
        tick();
        rst         = 1'b0;
        restore_sel = 1'b0;
        hold_q      = '0;
        hold_r      = '0;
        hold_o      = 1'b0;
        check("midreset_busy", id, busy, 0);
        check("midreset_quotient", id, quotient, 0);
        check("midreset_remainder", id, remainder, 0);
        tick();
        check("midreset_idle_busy", id, busy, 0);
        check("midreset_idle_finish", id, restore_finish, 0);
        run_vec(id, vecs[6]);
        id++;

        // restore_sel held high: one conversion every W+2 cycles, inputs changed mid-CONVERT.
        hv[0] = vecs[0];
        hv[1] = vecs[9];
        hv[2] = vecs[6];
        hv[3] = vecs[11];
        restore_sel = 1'b1;
        cap = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            drive_inputs(hv[k]);
            push_exp(id, hv[k], cap + int'(W));
            id++;
            tick();
            scramble_inputs();
            if (k == 3) restore_sel = 1'b0;
            while (cyc < cap + int'(W) + 1) tick();
            cap = cap + int'(W) + 2;
        end

        for (int i = 0; i < 40 && sb_q.size() > 0; i++) tick();
        while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missing_finish (id %0d): no completion seen, required one at cycle %0d", mon_e.id, mon_e.due);
        end
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
